des_sbox_feeder: RTL and testbench

Iterative DES round-input generator sitting directly upstream of the eight S-box lookups (S1–S8). It holds the key schedule (PC-1, per-round rotations, PC-2), expands each incoming 32-bit right half with the E table, XORs in the current subkey, and presents the registered 48-bit result as the eight 6-bit S-box inputs. One key load serves 16 rounds in encrypt or decrypt subkey order, with valid/ready handshakes on both sides.

---
 rtl/des_sbox_feeder.sv | 242 ++++++++++++++++++++++++
 tb/tb_des_sbox_feeder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_feeder.sv
// des_sbox_feeder: iterative DES round-input generator feeding S1..S8.
// Holds the key schedule (PC-1, rotations, PC-2), expands R with E, XORs the
// current subkey and registers the 48-bit S-box input word.
// Optional feature macro: DES_KEY_PARITY_CHECK_EN (odd parity check per key byte).
// Bit numbering: DES bit n of key (1 = MSB) is key[64-n]; likewise r_in[32-n], s_in_bus[48-n].
module des_sbox_feeder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic [31:0] r_in,
  input  logic        r_valid,
  output logic        r_ready,
  output logic [47:0] s_in_bus,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  key_idx,
  output logic        busy,
  output logic        done,
  output logic        key_err
);

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned R_W    = 32;
  localparam int unsigned SB_W   = 48;

  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_TAB [SB_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};

  localparam int unsigned E_TAB [SB_W] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // PC-1: 64-bit key to 56-bit {C0,D0}
  function automatic logic [CD_W-1:0] f_pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] o;
    o = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      o[6'(int'(CD_W) - 1 - i)] = k[6'(int'(KEY_W) - int'(PC1_TAB[i]))];
    end
    return o;
  endfunction

  // PC-2: {C,D} to 48-bit subkey
  function automatic logic [SB_W-1:0] f_pc2(input logic [HALF_W-1:0] c,
                                            input logic [HALF_W-1:0] d);
    logic [CD_W-1:0] cd;
    logic [SB_W-1:0] o;
    cd = {c, d};
    o  = '0;
    for (int i = 0; i < int'(SB_W); i++) begin
      o[6'(int'(SB_W) - 1 - i)] = cd[6'(int'(CD_W) - int'(PC2_TAB[i]))];
    end
    return o;
  endfunction

  // E expansion: 32-bit R to 48 bits
  function automatic logic [SB_W-1:0] f_expand(input logic [R_W-1:0] r);
    logic [SB_W-1:0] o;
    o = '0;
    for (int i = 0; i < int'(SB_W); i++) begin
      o[6'(int'(SB_W) - 1 - i)] = r[5'(int'(R_W) - int'(E_TAB[i]))];
    end
    return o;
  endfunction

  function automatic logic [HALF_W-1:0] f_rotl(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] f_rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  // Subkeys 1, 2, 9 and 16 use a single-bit rotation; all others use two
  function automatic logic f_shift_one(input logic [4:0] n);
    return (n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [HALF_W-1:0]  r_c;
  logic [HALF_W-1:0]  r_d;
  logic [3:0]         r_cnt;
  logic               r_decrypt;
  logic [SB_W-1:0]    r_s_in_bus;
  logic               r_s_valid;
  logic [3:0]         r_key_idx;
  logic               r_done;

  logic [CD_W-1:0]    w_cd_pc1;
  logic [SB_W-1:0]    w_subkey;
  logic [SB_W-1:0]    w_expanded;
  logic               w_key_ok;
  logic               w_load;
  logic               w_accept;
  logic               w_out_hs;
  logic               w_one;
  logic [HALF_W-1:0]  w_c_nxt;
  logic [HALF_W-1:0]  w_d_nxt;

  assign w_cd_pc1   = f_pc1(key);
  assign w_subkey   = f_pc2(r_c, r_d);
  assign w_expanded = f_expand(r_in);
  assign w_load     = (r_state == ST_IDLE) && start && w_key_ok;
  assign w_accept   = r_valid && r_ready;
  assign w_out_hs   = r_s_valid && s_ready;

  // Rotation amount after the subkey just used, in the active direction
  assign w_one   = r_decrypt ? f_shift_one(5'd16 - {1'b0, r_cnt})
                             : f_shift_one({1'b0, r_cnt} + 5'd2);
  assign w_c_nxt = r_decrypt ? f_rotr(r_c, !w_one) : f_rotl(r_c, !w_one);
  assign w_d_nxt = r_decrypt ? f_rotr(r_d, !w_one) : f_rotl(r_d, !w_one);

  assign s_in_bus = r_s_in_bus;
  assign s_valid  = r_s_valid;
  assign key_idx  = r_key_idx;
  assign done     = r_done;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic r_key_err;

  assign w_key_ok = &{^key[63:56], ^key[55:48], ^key[47:40], ^key[39:32],
                      ^key[31:24], ^key[23:16], ^key[15:8],  ^key[7:0]};
  assign key_err  = r_key_err;

  // Parity error flag, updated by every start seen in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_key_err <= !w_key_ok;
    end
  end
`else
  logic w_unused_parity;

  assign w_key_ok        = 1'b1;
  assign key_err         = 1'b0;
  assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_load) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && (r_cnt == 4'd15)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_out_hs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; r_ready lets a new result replace one being consumed
  always_comb begin
    r_ready = 1'b0;
    busy    = 1'b0;
    case (r_state)
      ST_RUN: begin
        r_ready = !r_s_valid || s_ready;
        busy    = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  // Key schedule, round counter and registered S-box input word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_decrypt  <= 1'b0;
      r_s_in_bus <= '0;
      r_s_valid  <= 1'b0;
      r_key_idx  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && w_out_hs;
      if (w_load) begin
        r_decrypt <= decrypt;
        r_cnt     <= '0;
        r_c       <= decrypt ? w_cd_pc1[CD_W-1:HALF_W] : f_rotl(w_cd_pc1[CD_W-1:HALF_W], 1'b0);
        r_d       <= decrypt ? w_cd_pc1[HALF_W-1:0]    : f_rotl(w_cd_pc1[HALF_W-1:0], 1'b0);
      end
      if (w_accept) begin
        r_s_in_bus <= w_expanded ^ w_subkey;
        r_key_idx  <= r_decrypt ? (4'd15 - r_cnt) : r_cnt;
        r_s_valid  <= 1'b1;
        r_cnt      <= r_cnt + 4'd1;
        r_c        <= w_c_nxt;
        r_d        <= w_d_nxt;
      end else if (w_out_hs) begin
        r_s_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_des_sbox_feeder.sv
// Directed bench for des_sbox_feeder using the classic key 133457799BBCDFF1.
module tb_des_sbox_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] key;
  logic        decrypt;
  logic [31:0] r_in;
  logic        r_valid;
  logic        r_ready;
  logic [47:0] s_in_bus;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  key_idx;
  logic        busy;
  logic        done;
  logic        key_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD  = 64'h133457799BBCDFF0;
  // E(F0AAF0AA) by hand
  localparam logic [47:0] E_F0AA   = 48'h7A15557A1555;
  localparam logic [47:0] KSUB [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  always #5 clk = ~clk;

  des_sbox_feeder u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .decrypt  (decrypt),
    .r_in     (r_in),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .s_in_bus (s_in_bus),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .key_idx  (key_idx),
    .busy     (busy),
    .done     (done),
    .key_err  (key_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_s_in_bus"}, 64'(s_in_bus), 64'd0);
    check_eq({tag, "_s_valid"},  64'(s_valid),  64'd0);
    check_eq({tag, "_key_idx"},  64'(key_idx),  64'd0);
    check_eq({tag, "_busy"},     64'(busy),     64'd0);
    check_eq({tag, "_done"},     64'(done),     64'd0);
    check_eq({tag, "_key_err"},  64'(key_err),  64'd0);
    check_eq({tag, "_r_ready"},  64'(r_ready),  64'd0);
  endtask

  // R for the n-th accepted round: first value, then alternating 0 / all-ones
  function automatic logic [31:0] r_pattern(input int n, input logic [31:0] first);
    if (n == 0) return first;
    return (n % 2 == 1) ? 32'hFFFFFFFF : 32'h0;
  endfunction

  // E(0)=0 and E(all ones)=all ones, so results are Kn, ~Kn or E_F0AA^Kn
  function automatic logic [47:0] exp_out(input logic [31:0] r, input int idx);
    case (r)
      32'h00000000: return KSUB[idx];
      32'hFFFFFFFF: return ~KSUB[idx];
      32'hF0AAF0AA: return E_F0AA ^ KSUB[idx];
      default:      return 48'h0;
    endcase
  endfunction

  // One keyed run; optional 5-cycle output stall at result stall_at,
  // optional reset once abort_at rounds have been accepted.
  task automatic do_run(input string tag, input logic dec, input logic [63:0] k,
                        input logic [31:0] r_first, input int stall_at, input int abort_at);
    logic [47:0] exp_q [$];
    int          idx_q [$];
    int          nacc = 0;
    int          nout = 0;
    int          cyc  = 0;
    int          stall_cnt = 0;
    int          idx;
    logic        in_stall;
    logic        aborted = 1'b0;
    logic [47:0] held_bus = '0;
    logic [3:0]  held_idx = '0;
    logic [47:0] exp_v;
    int          exp_i;

    @(negedge clk);
    key = k; decrypt = dec; start = 1'b1; r_valid = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check_eq({tag, "_key_err_after_start"}, 64'(key_err), 64'd0);

    while (nout < 16 && cyc < 60) begin
      if (abort_at >= 0 && nacc == abort_at) begin
        rst_n = 1'b0; r_valid = 1'b0; s_ready = 1'b1; start = 1'b0;
        aborted = 1'b1;
        break;
      end
      in_stall = (stall_at >= 0) && (nout == stall_at) && (stall_cnt < 5);
      s_ready  = !in_stall;
      r_valid  = 1'b1;
      r_in     = r_pattern(nacc, r_first);
      // a start pulse mid-run carrying a different key and direction must be ignored
      start    = (cyc == 6);
      key      = (cyc == 6) ? 64'h0 : k;
      decrypt  = (cyc == 6) ? !dec : dec;
      #1;
      if (in_stall) begin
        check_eq({tag, "_stall_valid"}, 64'(s_valid), 64'd1);
        check_eq({tag, "_stall_r_ready"}, 64'(r_ready), 64'd0);
        if (stall_cnt == 0) begin
          held_bus = s_in_bus;
          held_idx = key_idx;
        end else begin
          check_eq({tag, "_stall_bus"}, 64'(s_in_bus), 64'(held_bus));
          check_eq({tag, "_stall_idx"}, 64'(key_idx), 64'(held_idx));
        end
        stall_cnt++;
      end
      if (s_valid && s_ready) begin
        if (exp_q.size() == 0) begin
          check_eq({tag, "_unexpected_output"}, 64'd1, 64'd0);
        end else begin
          exp_v = exp_q.pop_front();
          exp_i = idx_q.pop_front();
          check_eq({tag, "_s_in_bus"}, 64'(s_in_bus), 64'(exp_v));
          check_eq({tag, "_key_idx"}, 64'(key_idx), 64'(exp_i));
        end
        nout++;
      end
      if (r_valid && r_ready) begin
        idx = dec ? 15 - nacc : nacc;
        exp_q.push_back(exp_out(r_in, idx));
        idx_q.push_back(idx);
        nacc++;
      end
      cyc++;
      @(negedge clk);
    end

    start = 1'b0; key = k; decrypt = dec; r_valid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      #1;
      check_reset({tag, "_rst1"});
      @(negedge clk);
      #1;
      check_reset({tag, "_rst2"});
      rst_n = 1'b1;
    end else begin
      check_eq({tag, "_timeout"}, 64'(cyc < 60), 64'd1);
      check_eq({tag, "_cycles"}, 64'(cyc), 64'(17 + ((stall_at >= 0) ? 5 : 0)));
      check_eq({tag, "_accepted"}, 64'(nacc), 64'd16);
      #1;
      check_eq({tag, "_done_pulse"}, 64'(done), 64'd1);
      check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check_eq({tag, "_r_ready_idle"}, 64'(r_ready), 64'd0);
      @(negedge clk);
      #1;
      check_eq({tag, "_done_clear"}, 64'(done), 64'd0);
      check_eq({tag, "_s_valid_idle"}, 64'(s_valid), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key = '0; decrypt = 1'b0;
    r_in = '0; r_valid = 1'b0; s_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    do_run("enc_f0aa", 1'b0, KEY_GOOD, 32'hF0AAF0AA, -1, -1);
    do_run("enc_stall", 1'b0, KEY_GOOD, 32'h0, 7, -1);
    do_run("dec", 1'b1, KEY_GOOD, 32'h0, -1, -1);
    do_run("enc_abort", 1'b0, KEY_GOOD, 32'h0, -1, 6);
    do_run("dec_after_rst", 1'b1, KEY_GOOD, 32'hFFFFFFFF, -1, -1);
    do_run("dec_abort", 1'b1, KEY_GOOD, 32'h0, -1, 6);
    do_run("enc_after_rst", 1'b0, KEY_GOOD, 32'h0, -1, -1);

`ifdef DES_KEY_PARITY_CHECK_EN
    @(negedge clk);
    key = KEY_BAD; decrypt = 1'b0; start = 1'b1; r_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("parity_key_err", 64'(key_err), 64'd1);
    check_eq("parity_busy", 64'(busy), 64'd0);
    check_eq("parity_r_ready", 64'(r_ready), 64'd0);
    @(negedge clk);
    #1;
    check_eq("parity_busy_hold", 64'(busy), 64'd0);
    check_eq("parity_key_err_hold", 64'(key_err), 64'd1);
    r_valid = 1'b0;
    do_run("parity_good", 1'b0, KEY_GOOD, 32'h0, -1, -1);
`else
    // parity bits are ignored, so the bad-parity key yields the same subkeys
    do_run("parity_ignored", 1'b0, KEY_BAD, 32'h0, -1, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "global timeout");
  end

endmodule
